mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Shares one single-ported 1024x32 synchronous memory between two requesters of the MIPS32 pipeline: instruction fetch (IF port) and load/store data access (DM port).
- Serialises accesses through a request/grant/response handshake with configurable memory wait states.
- Gives the data port priority, with a starvation guard for fetch.
- Supports a fetch flush so a taken branch can discard an in-flight instruction fetch.

Parameters:
- ADDR_W, 10, memory word-address width
- DATA_W, 32, data width
- WAIT_CYC, 1, ACCESS-state cycles per transaction; legal range 1..15
- STARVE_MAX, 4, consecutive DM grants allowed while if_req is pending before IF is forced

Ports:
- clk1  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high with stable if_addr until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_flush  in  1  discard any accepted, not-yet-responded fetch
- if_gnt  out  1  fetch accepted (one-cycle pulse)
- if_rvalid  out  1  fetch data valid (one-cycle pulse)
- if_rdata  out  DATA_W  fetch data
- dm_req  in  1  data request; held high with stable fields until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted (one-cycle pulse)
- dm_rvalid  out  1  load data valid, or store acknowledge (one-cycle pulse)
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data; valid the cycle after mem_en, held until the next mem_en
- busy  out  1  state != IDLE
- owner  out  1  0 = IF, 1 = DM; port of the current or last transaction

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; all gnt, rvalid, mem_en and mem_we = 0.
  - rdata outputs, mem_addr and mem_wdata = 0; owner = 0; starvation counter = 0; wait counter = 0; flush flag = 0.
  - Reset mid-transaction aborts it with no response; a store already strobed may have written.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is present, pick a winner and assert that port's gnt combinationally in the same cycle.
  - Latch addr, we and wdata (IF: we = 0) and owner; go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - Only dm_req: DM wins. Only if_req: IF wins.
  - Both requesting: DM wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - starve_cnt increments on a DM grant made while if_req = 1, saturating at STARVE_MAX.
  - starve_cnt clears on any IF grant, and on any grant made while if_req = 0.
- ACCESS:
  - Lasts exactly WAIT_CYC cycles, counted by the wait counter.
  - mem_en = 1 and mem_we = latched we in the first ACCESS cycle only.
  - mem_addr and mem_wdata are driven from the latches for the whole state.
  - Go to RESP after the last ACCESS cycle.
- RESP (one cycle):
  - The owner's rvalid = 1. Loads and fetches present mem_rdata on the owner's rdata register, which holds until the next response. Stores assert dm_rvalid only, and dm_rdata holds its previous value.
  - Then go to IDLE. No grant is issued in RESP.
- Latency and throughput:
  - Request in IDLE at cycle 0 gives gnt at cycle 0 and rvalid at cycle WAIT_CYC+1.
  - Next grant earliest at cycle WAIT_CYC+2, i.e. one transaction per WAIT_CYC+2 cycles.
- Flush:
  - if_flush = 1 while owner = IF and state is ACCESS or RESP sets a flush flag.
  - With the flag set, if_rvalid is suppressed in RESP and if_rdata is not updated. The memory read still completes.
  - The flag clears on return to IDLE.
  - if_flush in IDLE has no effect; a fetch granted in the same cycle is not flushed.
  - if_flush has no effect on DM transactions.
- Request drop: a requester dropping req before gnt is legal and gets nothing. After gnt the transaction always completes.
- Addresses use the full ADDR_W bits; there is no range check.

Decomposition:
- Shared package mips_mem_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - owner constants OWN_IF = 0, OWN_DM = 1;
  - default widths ADDR_W / DATA_W, shared with the pipeline.
- Single module; no sub-module is warranted.

Test Plan:
- Single IF read, WAIT_CYC = 1, mem[5] = 0x2000_0001, if_req@0 with addr 5 -> if_gnt@0, mem_en@1 addr 5, if_rvalid@2 with if_rdata 0x2000_0001, busy 1..2.
- DM store then load, addr 0x3FF, data 0xDEADBEEF -> dm_rvalid on the store with mem_we = 1 only in its first ACCESS cycle; the following load returns 0xDEADBEEF (also checks the 0x3FF boundary).
- Both req held continuously, STARVE_MAX = 4 -> grant order DM, DM, DM, DM, IF, DM...; starve_cnt never exceeds 4.
- WAIT_CYC = 3 -> mem_en is a single pulse, busy for 4 cycles, rvalid exactly 4 cycles after gnt, next gnt 5 cycles after the first.
- IF read with if_flush asserted in its RESP cycle -> no if_rvalid and if_rdata unchanged; a DM request pending in the same cycle is granted the next cycle.
- rst_n low during ACCESS -> mem_en, gnt and rvalid drop immediately; after release the state is IDLE, a fresh IF request completes normally, and no stale rvalid appears.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS32 fetch/data memory arbiter:
// FSM states, owner encoding and default bus widths used by the pipeline.
package mips_mem_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Arbitrates one single-ported synchronous memory between instruction fetch
// and load/store access; DM has priority, with a starvation guard for IF.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = mips_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W     = mips_mem_pkg::DATA_W,
  parameter int unsigned WAIT_CYC   = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned     SC_W       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [3:0]      WAIT_LAST  = 4'(WAIT_CYC - 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  arb_state_e        state;
  logic [3:0]        wait_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              flush_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              if_rv_q;
  logic              dm_rv_q;

  logic pick_dm;
  logic pick_if;
  logic grant;
  logic flush_now;
  logic if_drop;

  always_comb begin
    pick_dm   = dm_req && !(if_req && (starve_cnt == STARVE_LIM));
    pick_if   = if_req && !pick_dm;
    grant     = (state == IDLE) && (pick_dm || pick_if);
    flush_now = if_flush && (owner_q == OWN_IF) && (state != IDLE);
    if_drop   = flush_q || flush_now;
  end

  // Grants are decided combinationally in IDLE and forced low while in reset.
  assign if_gnt    = rst_n && grant && pick_if;
  assign dm_gnt    = rst_n && grant && pick_dm;

  // mem_rdata only becomes valid in RESP for short waits, so the response
  // cycle bypasses the holding register; the register keeps it afterwards.
  assign if_rvalid = if_rv_q && !flush_now;
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign dm_rvalid = dm_rv_q;
  assign dm_rdata  = (dm_rv_q && !we_q) ? mem_rdata : dm_rdata_q;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
  assign owner     = owner_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      flush_q    <= 1'b0;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_rv_q    <= 1'b0;
      dm_rv_q    <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_rv_q  <= 1'b0;
      dm_rv_q  <= 1'b0;
      case (state)
        IDLE: begin
          flush_q <= 1'b0;
          if (grant) begin
            owner_q  <= pick_dm ? OWN_DM : OWN_IF;
            addr_q   <= pick_dm ? dm_addr : if_addr;
            we_q     <= pick_dm && dm_we;
            if (pick_dm) begin
              wdata_q <= dm_wdata;
            end
            mem_en_q <= 1'b1;
            mem_we_q <= pick_dm && dm_we;
            wait_cnt <= '0;
            // Count DM wins only while fetch is actually waiting.
            if (pick_if || !if_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (flush_now) begin
            flush_q <= 1'b1;
          end
          if (wait_cnt == WAIT_LAST) begin
            if (owner_q == OWN_DM) begin
              dm_rv_q <= 1'b1;
            end else begin
              if_rv_q <= !if_drop;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (owner_q == OWN_IF && !if_drop) begin
            if_rdata_q <= mem_rdata;
          end
          if (owner_q == OWN_DM && !we_q) begin
            dm_rdata_q <= mem_rdata;
          end
          flush_q  <= 1'b0;
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_one_grant : assert property (@(posedge clk1) disable iff (!rst_n) !(if_gnt && dm_gnt));
  a_strobe_in_access : assert property (@(posedge clk1) disable iff (!rst_n) mem_en |-> (state == ACCESS));

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench: randomized requesters against a transaction-level
// model of the arbiter, plus directed scenarios with hand-computed values.
module tb_mips_mem_arbiter;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned W    = 1;
  localparam int unsigned SMAX = 4;

  logic clk1 = 1'b0;
  logic rst_n;
  always #5 clk1 = ~clk1;

  logic          if_req, if_flush, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy, owner;

  logic          w3_req;
  logic [AW-1:0] w3_addr, w3_mem_addr;
  logic [DW-1:0] w3_if_rdata, w3_dm_rdata, w3_mem_wdata, w3_mem_rdata;
  logic          w3_if_gnt, w3_if_rvalid, w3_dm_gnt, w3_dm_rvalid;
  logic          w3_mem_en, w3_mem_we, w3_busy, w3_owner;

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W), .STARVE_MAX(SMAX)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(3), .STARVE_MAX(SMAX)) dut_w3 (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(w3_req), .if_addr(w3_addr), .if_flush(1'b0),
    .if_gnt(w3_if_gnt), .if_rvalid(w3_if_rvalid), .if_rdata(w3_if_rdata),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr('0), .dm_wdata('0),
    .dm_gnt(w3_dm_gnt), .dm_rvalid(w3_dm_rvalid), .dm_rdata(w3_dm_rdata),
    .mem_en(w3_mem_en), .mem_we(w3_mem_we), .mem_addr(w3_mem_addr), .mem_wdata(w3_mem_wdata),
    .mem_rdata(w3_mem_rdata), .busy(w3_busy), .owner(w3_owner)
  );

  // Environment memories: data valid the cycle after the strobe, held after.
  logic [DW-1:0] env_mem [1024];
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      mem_rdata <= env_mem[mem_addr];
    end
  end
  always @(posedge clk1) begin
    if (w3_mem_en) w3_mem_rdata <= 32'hA5A5_0000 ^ {22'd0, w3_mem_addr};
  end

  int unsigned cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic mid();
    @(negedge clk1);
  endtask

  // Transaction-level model: one outstanding transaction, timed from its grant.
  logic [DW-1:0] ref_mem [1024];
  logic          m_act = 1'b0, m_own = 1'b0, m_we = 1'b0, m_fl = 1'b0;
  int unsigned   m_g = 0, m_starve = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_last_if = '0, m_last_dm = '0;

  always @(negedge clk1) begin
    logic [DW-1:0] ld, e_ifd, e_dmd;
    logic e_ig, e_dg, e_en, e_resp, e_irv, e_drv;
    if (!rst_n) begin
      chk("rst_gnt", {if_gnt, dm_gnt}, 0);
      chk("rst_rvalid", {if_rvalid, dm_rvalid}, 0);
      chk("rst_mem_en_we", {mem_en, mem_we}, 0);
      chk("rst_busy_owner", {busy, owner}, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      m_act = 1'b0; m_own = 1'b0; m_starve = 0; m_fl = 1'b0;
      m_last_if = '0; m_last_dm = '0;
    end else begin
      if (m_act && cyc >= m_g + W + 2) m_act = 1'b0;
      e_ig = 1'b0;
      e_dg = 1'b0;
      if (!m_act) begin
        if (dm_req && !(if_req && m_starve == SMAX)) e_dg = 1'b1;
        else if (if_req) e_ig = 1'b1;
      end
      e_en   = m_act && (cyc == m_g + 1);
      e_resp = m_act && (cyc == m_g + W + 1);
      if (m_act && m_own == 1'b0 && if_flush) m_fl = 1'b1;
      ld    = ref_mem[m_addr];
      e_irv = e_resp && (m_own == 1'b0) && !m_fl;
      e_drv = e_resp && (m_own == 1'b1);
      e_ifd = e_irv ? ld : m_last_if;
      e_dmd = (e_drv && !m_we) ? ld : m_last_dm;
      chk("if_gnt", if_gnt, e_ig);
      chk("dm_gnt", dm_gnt, e_dg);
      chk("busy", busy, m_act);
      chk("owner", owner, m_own);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_en && m_we);
      if (e_en) begin
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wd);
      end
      chk("if_rvalid", if_rvalid, e_irv);
      chk("dm_rvalid", dm_rvalid, e_drv);
      chk("if_rdata", if_rdata, e_ifd);
      chk("dm_rdata", dm_rdata, e_dmd);
      m_last_if = e_ifd;
      m_last_dm = e_dmd;
      if (e_ig || e_dg) begin
        m_act  = 1'b1;
        m_g    = cyc;
        m_own  = e_dg;
        m_fl   = 1'b0;
        m_addr = e_dg ? dm_addr : if_addr;
        m_we   = e_dg && dm_we;
        m_wd   = dm_wdata;
        if (e_ig || !if_req) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        if (m_we) ref_mem[m_addr] = m_wd;
      end
    end
  end

  initial begin
    logic [9:0]    order;
    logic [11:0]   g3, e3, b3, v3;
    logic [DW-1:0] pre, rd4;
    logic          saw_i, saw_d;
    int unsigned   n;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    w3_req = 1'b0; w3_addr = 10'd3;
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[5]  = 32'h2000_0001; ref_mem[5]  = 32'h2000_0001;
    env_mem[12] = 32'h1234_5678; ref_mem[12] = 32'h1234_5678;
    repeat (3) tick();
    rst_n = 1'b1;

    // Single fetch, WAIT_CYC = 1
    tick(); if_req = 1'b1; if_addr = 10'd5;
    mid(); chk("t1_gnt", if_gnt, 1); chk("t1_busy0", busy, 0);
    tick(); if_req = 1'b0;
    mid(); chk("t1_en", mem_en, 1); chk("t1_addr", mem_addr, 5); chk("t1_busy1", busy, 1);
    tick();
    mid(); chk("t1_rv", if_rvalid, 1); chk("t1_data", if_rdata, 32'h2000_0001); chk("t1_busy2", busy, 1);
    tick();
    mid(); chk("t1_idle", busy, 0); chk("t1_hold", if_rdata, 32'h2000_0001);

    // WAIT_CYC = 3 instance, request held for back-to-back fetches
    tick(); w3_req = 1'b1;
    rd4 = '0;
    for (int k = 0; k < 12; k++) begin
      mid();
      g3[k] = w3_if_gnt; e3[k] = w3_mem_en; b3[k] = w3_busy; v3[k] = w3_if_rvalid;
      if (k == 4) rd4 = w3_if_rdata;
      chk("w3_dm_quiet", {w3_dm_gnt, w3_dm_rvalid, w3_owner, w3_mem_we}, 0);
      chk("w3_dm_rdata", w3_dm_rdata, 0);
      tick();
    end
    w3_req = 1'b0;
    chk("w3_gnt", g3, 12'b0100_0010_0001);
    chk("w3_mem_en", e3, 12'b1000_0100_0010);
    chk("w3_busy", b3, 12'b1011_1101_1110);
    chk("w3_rvalid", v3, 12'b0010_0001_0000);
    chk("w3_rdata", rd4, 32'hA5A5_0003);

    // Store then load at the top word address
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 32'hDEAD_BEEF;
    mid(); chk("st_gnt", dm_gnt, 1);
    tick(); dm_req = 1'b0;
    mid(); chk("st_en_we", {mem_en, mem_we}, 2'b11); chk("st_addr", mem_addr, 10'h3FF);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    mid(); chk("st_rv", dm_rvalid, 1); chk("st_we_off", mem_we, 0);
    tick(); dm_req = 1'b1; dm_we = 1'b0;
    mid(); chk("ld_gnt", dm_gnt, 1);
    tick(); dm_req = 1'b0;
    mid();
    tick();
    mid(); chk("ld_rv", dm_rvalid, 1); chk("ld_data", dm_rdata, 32'hDEAD_BEEF);

    // Both requesters held continuously
    tick(); if_req = 1'b1; if_addr = 10'd20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd21;
    n = 0; order = '0;
    repeat (36) begin
      mid();
      if (n < 10 && (if_gnt || dm_gnt)) begin
        order[n] = dm_gnt;
        n++;
      end
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("starve_n", n, 10);
    chk("starve_order", order, 10'b0111101111);

    // Fetch flushed in its response cycle with a data request waiting
    repeat (3) tick();
    if_req = 1'b1; if_addr = 10'd7;
    mid(); chk("fl_gnt", if_gnt, 1); pre = if_rdata;
    tick(); if_req = 1'b0;
    mid();
    tick(); if_flush = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd9;
    mid(); chk("fl_rv", if_rvalid, 0); chk("fl_hold", if_rdata, pre);
    chk("fl_nognt", dm_gnt, 0); chk("fl_busy", busy, 1);
    tick(); if_flush = 1'b0;
    mid(); chk("fl_dm_gnt", dm_gnt, 1); chk("fl_hold2", if_rdata, pre);
    tick(); dm_req = 1'b0;

    // Reset asserted in the middle of an access
    repeat (3) tick();
    if_req = 1'b1; if_addr = 10'd12;
    mid(); chk("rs_gnt", if_gnt, 1);
    tick(); if_req = 1'b0;
    mid(); chk("rs_en", mem_en, 1);
    #1 rst_n = 1'b0; if_req = 1'b1;
    #1;
    chk("rs_en_drop", mem_en, 0); chk("rs_busy_drop", busy, 0);
    chk("rs_gnt_drop", if_gnt, 0); chk("rs_rv_drop", {if_rvalid, dm_rvalid}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    mid(); chk("rs_regnt", if_gnt, 1); chk("rs_no_stale", if_rvalid, 0);
    tick(); if_req = 1'b0;
    mid();
    tick();
    mid(); chk("rs_rv", if_rvalid, 1); chk("rs_data", if_rdata, 32'h1234_5678);

    // Randomized traffic; requests held with stable fields until granted
    saw_i = 1'b0; saw_d = 1'b0;
    repeat (3000) begin
      tick();
      if (if_req && !saw_i) begin
        if ($urandom_range(0, 15) == 0) if_req = 1'b0;
      end else begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = AW'($urandom_range(0, 31));
      end
      if (dm_req && !saw_d) begin
        if ($urandom_range(0, 15) == 0) dm_req = 1'b0;
      end else begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_addr  = ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom_range(0, 31));
        dm_wdata = $urandom;
      end
      if_flush = ($urandom_range(0, 5) == 0);
      mid();
      saw_i = if_gnt;
      saw_d = dm_gnt;
    end
    tick();
    if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
